descriptor_dispatch_mq: RTL

Parametrised descriptor dispatcher for the network input path. It sits between descriptor generation and the queue/host/HCP consumers. For each frame descriptor it makes a per-class admission decision against free-buffer thresholds, claims a buffer id from the buffer manager, and inserts that id into the descriptor. It then routes the descriptor to one of N_DEST consumers with a hold-until-ack handshake, adds a bufid-wait timeout, and exposes discard/sent statistics.

---
 rtl/descriptor_dispatch_mq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/descriptor_dispatch_mq.sv
// Descriptor dispatcher: admits frames against per-class free-buffer thresholds, claims a bufid and routes the descriptor to one consumer.
// Latency: accept->discard pulse 1 cycle; accept->descriptor write 2 cycles when a bufid is already offered.
// Backpressure: one descriptor in flight; ready only when idle, write held until the addressed consumer acks.
module descriptor_dispatch_mq #(
    parameter logic [3:0] INPORT  = 4'b0000,
    parameter int         N_DEST  = 3,
    parameter int         DEST_W  = 2,
    parameter int         DESC_W  = 40,
    parameter int         BUFID_W = 9,
    parameter int         TIMEOUT = 1023
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_descriptor_valid,
    input  logic [DESC_W-1:0]   iv_descriptor,
    input  logic [DEST_W-1:0]   iv_dest,
    input  logic [1:0]          iv_class,
    output logic                o_descriptor_ready,
    input  logic [BUFID_W-1:0]  iv_free_bufid_num,
    input  logic [BUFID_W-1:0]  iv_rc_threshold_value,
    input  logic [BUFID_W-1:0]  iv_hpriority_be_threshold_value,
    input  logic [BUFID_W-1:0]  iv_lpriority_be_threshold_value,
    input  logic                i_pkt_bufid_wr,
    input  logic [BUFID_W-1:0]  iv_pkt_bufid,
    output logic                o_pkt_bufid_ack,
    output logic                o_pkt_bufid_wr,
    output logic [BUFID_W-1:0]  ov_pkt_bufid,
    output logic                o_pkt_discard,
    output logic [N_DEST-1:0]   ov_descriptor_wr,
    output logic [DESC_W-1:0]   ov_descriptor,
    input  logic [N_DEST-1:0]   iv_descriptor_ack,
    output logic [31:0]         ov_pkt_discard_cnt,
    output logic [31:0]         ov_desc_sent_cnt,
    output logic [1:0]          ov_dispatch_state
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BUFID = 2'd1,
        SEND       = 2'd2,
        DISCARD    = 2'd3
    } state_t;

    localparam logic [DEST_W:0]   N_DEST_V  = N_DEST[DEST_W:0];
    localparam logic [31:0]       WAIT_LAST = 32'(TIMEOUT - 1);
    localparam logic [N_DEST-1:0] DEST_ONE  = N_DEST'(1);

    state_t                  state;
    logic [DESC_W-5:BUFID_W] desc_mid;   // generator-owned middle fields, passed through untouched
    logic [DEST_W-1:0]       dest_q;
    logic [31:0]             wait_cnt;
    logic                    accept;
    logic                    thr_hit;
    logic                    dest_bad;
    logic                    adm_discard;
    logic                    ack_hit;
    logic                    unused_desc_bits;

    assign o_descriptor_ready = (state == IDLE);
    assign ov_dispatch_state  = state;
    assign accept             = i_descriptor_valid & o_descriptor_ready;
    assign dest_bad           = {1'b0, iv_dest} >= N_DEST_V;
    assign adm_discard        = dest_bad | thr_hit;
    // Only the ack bit of the destination currently being written counts.
    assign ack_hit            = |(iv_descriptor_ack & ov_descriptor_wr);
    // Inport and bufid fields of the incoming descriptor are overwritten here.
    assign unused_desc_bits   = ^{iv_descriptor[DESC_W-1:DESC_W-4], iv_descriptor[BUFID_W-1:0]};

    // Per-class admission: drop when free buffers are at or below the class threshold; TS is never dropped.
    always_comb begin
        thr_hit = 1'b0;
        case (iv_class)
            2'd0:    thr_hit = (iv_free_bufid_num <= iv_rc_threshold_value);
            2'd1:    thr_hit = (iv_free_bufid_num <= iv_hpriority_be_threshold_value);
            2'd2:    thr_hit = (iv_free_bufid_num <= iv_lpriority_be_threshold_value);
            default: thr_hit = 1'b0;
        endcase
    end

    // Dispatch FSM with registered pulses, held descriptor write and statistics counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state              <= IDLE;
            desc_mid           <= '0;
            dest_q             <= '0;
            wait_cnt           <= '0;
            o_pkt_bufid_ack    <= 1'b0;
            o_pkt_bufid_wr     <= 1'b0;
            ov_pkt_bufid       <= '0;
            o_pkt_discard      <= 1'b0;
            ov_descriptor_wr   <= '0;
            ov_descriptor      <= '0;
            ov_pkt_discard_cnt <= '0;
            ov_desc_sent_cnt   <= '0;
        end else begin
            o_pkt_bufid_ack <= 1'b0;
            o_pkt_bufid_wr  <= 1'b0;
            o_pkt_discard   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        desc_mid <= iv_descriptor[DESC_W-5:BUFID_W];
                        dest_q   <= iv_dest;
                        wait_cnt <= '0;
                        if (adm_discard) begin
                            state              <= DISCARD;
                            o_pkt_discard      <= 1'b1;
                            ov_pkt_discard_cnt <= ov_pkt_discard_cnt + 32'd1;
                        end else begin
                            state <= WAIT_BUFID;
                        end
                    end
                end
                WAIT_BUFID: begin
                    // A bufid arriving in the last allowed cycle still wins over the timeout.
                    if (i_pkt_bufid_wr) begin
                        o_pkt_bufid_ack  <= 1'b1;
                        o_pkt_bufid_wr   <= 1'b1;
                        ov_pkt_bufid     <= iv_pkt_bufid;
                        ov_descriptor    <= {INPORT, desc_mid, iv_pkt_bufid};
                        ov_descriptor_wr <= DEST_ONE << dest_q;
                        state            <= SEND;
                    end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
                        state              <= DISCARD;
                        o_pkt_discard      <= 1'b1;
                        ov_pkt_discard_cnt <= ov_pkt_discard_cnt + 32'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                SEND: begin
                    if (ack_hit) begin
                        ov_descriptor_wr <= '0;
                        ov_desc_sent_cnt <= ov_desc_sent_cnt + 32'd1;
                        state            <= IDLE;
                    end
                end
                DISCARD: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
